ram_sink: RTL and testbench

Capture buffer for the user-IP-to-host direction of the PCIe memory bridge. The user IP streams words in through a write-only port with an auto-incrementing pointer. The host reads the captured block, plus a status/control register pair, through an Avalon-MM slave port on the PCIe-side interconnect. A three-state capture FSM gates acceptance, detects end-of-block, and raises a level interrupt.

---
 rtl/ram_sink_pkg.sv | 25 ++
 rtl/ram_sink_if.sv | 26 ++
 rtl/ram_sink_dpram.sv | 26 ++
 rtl/ram_sink.sv | 156 +++++++++++++++
 tb/tb_ram_sink.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_sink_pkg.sv
// Shared definitions for the ram_sink capture buffer: FSM encoding,
// CSR word offsets and CSR bit positions.
package ram_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // CSR word offsets inside the CSR region (address bit W = 1)
    localparam int CSR_STATUS  = 0;
    localparam int CSR_CONTROL = 1;

    // STATUS flag positions, counted down from the MSB of the data word
    localparam int STAT_DONE_FROM_MSB = 0;
    localparam int STAT_OVF_FROM_MSB  = 1;
    localparam int STAT_CAP_FROM_MSB  = 2;

    // CONTROL bit positions
    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_ARM_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

endpackage

// File: rtl/ram_sink_if.sv
// Host Avalon-MM slave signals plus the user-IP write stream of ram_sink.
interface ram_sink_if #(
    parameter int B = 32,
    parameter int W = 10
);
    logic         read_n;
    logic         write_n;
    logic [W:0]   address;
    logic [B-1:0] writedata;
    logic [B-1:0] readdata;
    logic         wr_en;
    logic [B-1:0] wr_data;
    logic         wr_last;
    logic         wr_ready;
    logic         irq;

    modport slave (
        input  read_n, write_n, address, writedata, wr_en, wr_data, wr_last,
        output readdata, wr_ready, irq
    );

    modport master (
        output read_n, write_n, address, writedata, wr_en, wr_data, wr_last,
        input  readdata, wr_ready, irq
    );
endinterface

// File: rtl/ram_sink_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module ram_sink_dpram #(
    parameter int B = 32,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic         re,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);
    logic [B-1:0] mem [0:(1<<W)-1];

    // Write port and registered read port; NBA ordering yields old-data reads
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ram_sink.sv
// ram_sink: captures a user-IP word stream into a RAM and exposes the block
// plus STATUS/CONTROL registers to the host over an Avalon-MM slave port.
module ram_sink
    import ram_sink_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 10
) (
    input  logic      clk,
    input  logic      reset,
    ram_sink_if.slave bus
);
    localparam int         DEPTH      = 1 << W;
    localparam logic [W:0] FULL_COUNT = (W+1)'(DEPTH);
    localparam logic [W:0] LAST_COUNT = (W+1)'(DEPTH - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   wr_ptr_q;
    logic [W:0]     count_q;
    logic           overflow_q;
    logic           irq_en_q;

    logic           host_rd, sel_csr, ctrl_wr, clear, arm;
    logic           accept, ram_we, last_word;
    logic [W-1:0]   csr_off;
    logic [B-1:0]   status_word, csr_word;

    logic           rd_vld_p0, rd_csr_p0;
    logic [B-1:0]   csr_data_p0, ram_q_p0;
    logic [B-1:0]   readdata_q;

    logic           unused_wdata;

    assign host_rd   = ~bus.read_n;
    assign sel_csr   = bus.address[W];
    assign csr_off   = bus.address[W-1:0];
    assign ctrl_wr   = ~bus.write_n & sel_csr & (csr_off == W'(CSR_CONTROL));
    assign clear     = ctrl_wr & bus.writedata[CTRL_CLEAR_BIT];
    assign arm       = ctrl_wr & bus.writedata[CTRL_ARM_BIT];

    // A word that coincides with clear is discarded, so it never reaches RAM
    assign accept    = bus.wr_en & (state_q == ST_CAPTURE);
    assign ram_we    = accept & ~clear;
    assign last_word = accept & (bus.wr_last | (count_q == LAST_COUNT));

    assign unused_wdata = ^bus.writedata[B-1:CTRL_IRQ_EN_BIT+1];

    // Capture FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture FSM next state; clear overrides everything including arm
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (arm)       state_d = ST_CAPTURE;
                ST_CAPTURE: if (last_word) state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Write pointer, word count, sticky overflow and irq enable
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= bus.writedata[CTRL_IRQ_EN_BIT];
            end
            if (clear) begin
                wr_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (ram_we) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (count_q != FULL_COUNT) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                if (bus.wr_en & (state_q != ST_CAPTURE)) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // CSR read mux; unused offsets read as zero
    always_comb begin
        status_word                          = '0;
        status_word[B-1-STAT_DONE_FROM_MSB]  = (state_q == ST_DONE);
        status_word[B-1-STAT_OVF_FROM_MSB]   = overflow_q;
        status_word[B-1-STAT_CAP_FROM_MSB]   = (state_q == ST_CAPTURE);
        status_word[W:0]                     = count_q;
        csr_word = '0;
        if (csr_off == W'(CSR_STATUS)) begin
            csr_word = status_word;
        end else if (csr_off == W'(CSR_CONTROL)) begin
            csr_word[CTRL_IRQ_EN_BIT] = irq_en_q;
        end
    end

    ram_sink_dpram #(.B(B), .W(W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .re    (host_rd & ~sel_csr),
        .raddr (bus.address[W-1:0]),
        .rdata (ram_q_p0)
    );

    // Stage p0: read request valid (RAM word is registered inside u_ram)
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p0 <= 1'b0;
        end else begin
            rd_vld_p0 <= host_rd;
        end
    end

    // Stage p0: region select and CSR snapshot at the request edge
    always_ff @(posedge clk) begin
        if (host_rd) begin
            rd_csr_p0   <= sel_csr;
            csr_data_p0 <= csr_word;
        end
    end

    // Stage p1: readdata register, holds when no read is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (rd_vld_p0) begin
            readdata_q <= rd_csr_p0 ? csr_data_p0 : ram_q_p0;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.wr_ready = (state_q == ST_CAPTURE);
    assign bus.irq      = (state_q == ST_DONE) & irq_en_q;

endmodule

// File: tb/tb_ram_sink.sv
// Bench for ram_sink: directed host/user stimulus, a behavioural model checked
// every cycle, and literal expectations at each scenario step.
module tb_ram_sink;
    localparam int B     = 32;
    localparam int W     = 10;
    localparam int DEPTH = 1 << W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_sink_if #(.B(B), .W(W)) bus ();

    ram_sink #(.B(B), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_active = 0;
    bit           m_cap, m_done, m_ovf, m_ien;
    int           m_cnt, m_ptr;
    logic [B-1:0] m_mem [DEPTH];
    bit           m_known [DEPTH];
    bit           m_pend, m_pend_known, m_rd_known;
    logic [B-1:0] m_pend_val, m_rd;

    always @(posedge clk) begin : model
        logic [B-1:0] v;
        bit vk, ctl, clr, arm, acc, was_cap, was_idle;
        int off;
        if (reset) begin
            m_cap = 0; m_done = 0; m_ovf = 0; m_ien = 0;
            m_cnt = 0; m_ptr = 0;
            m_rd = '0; m_rd_known = 1; m_pend = 0;
            m_active = 1;
        end else if (m_active) begin
            if (m_pend) begin
                m_rd = m_pend_val;
                m_rd_known = m_pend_known;
            end
            m_pend = !bus.read_n;
            if (!bus.read_n) begin
                off = int'(bus.address[W-1:0]);
                v = '0;
                vk = 1;
                if (!bus.address[W]) begin
                    v = m_mem[off];
                    vk = m_known[off];
                end else if (off == 0) begin
                    v[B-1] = m_done;
                    v[B-2] = m_ovf;
                    v[B-3] = m_cap;
                    v[W:0] = (W+1)'(m_cnt);
                end else if (off == 1) begin
                    v[2] = m_ien;
                end
                m_pend_val = v;
                m_pend_known = vk;
            end
            ctl = !bus.write_n && bus.address[W] && (bus.address[W-1:0] == 1);
            clr = ctl && bus.writedata[0];
            arm = ctl && bus.writedata[1];
            was_cap  = m_cap;
            was_idle = !m_cap && !m_done;
            acc = bus.wr_en && was_cap;
            if (bus.wr_en && !was_cap) m_ovf = 1;
            if (acc && !clr) begin
                m_mem[m_ptr] = bus.wr_data;
                m_known[m_ptr] = 1;
                m_ptr = (m_ptr + 1) % DEPTH;
                m_cnt = m_cnt + 1;
                if (bus.wr_last || m_cnt == DEPTH) begin
                    m_cap = 0;
                    m_done = 1;
                end
            end
            if (ctl) m_ien = bus.writedata[2];
            if (clr) begin
                m_cap = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_ptr = 0;
            end else if (arm && was_idle) begin
                m_cap = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_active) begin
            check("wr_ready_model", {{(B-1){1'b0}}, bus.wr_ready}, {{(B-1){1'b0}}, m_cap});
            check("irq_model", {{(B-1){1'b0}}, bus.irq}, {{(B-1){1'b0}}, m_done & m_ien});
            if (m_rd_known) check("readdata_model", bus.readdata, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input int off, input logic [B-1:0] d);
        bus.address   = {1'b1, W'(off)};
        bus.writedata = d;
        bus.write_n   = 1'b0;
        tick();
        bus.write_n   = 1'b1;
    endtask

    task automatic host_read(input logic [W:0] a, output logic [B-1:0] d);
        bus.address = a;
        bus.read_n  = 1'b0;
        tick();
        bus.read_n  = 1'b1;
        tick();
        d = bus.readdata;
    endtask

    function automatic logic [W:0] ram_a(input int k);
        return {1'b0, W'(k)};
    endfunction

    function automatic logic [W:0] csr_a(input int k);
        return {1'b1, W'(k)};
    endfunction

    function automatic logic [B-1:0] b1(input logic x);
        return {{(B-1){1'b0}}, x};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [B-1:0] rd;
        reset = 1'b1;
        bus.read_n = 1'b1; bus.write_n = 1'b1;
        bus.address = '0; bus.writedata = '0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state and drop while idle
        check("reset_wr_ready", b1(bus.wr_ready), '0);
        check("reset_irq", b1(bus.irq), '0);
        check("reset_readdata", bus.readdata, '0);
        host_read(csr_a(0), rd);
        check("reset_status", rd, 32'h0000_0000);
        bus.wr_en = 1'b1; bus.wr_data = 32'h99; tick(); bus.wr_en = 1'b0;
        check("idle_wr_ready", b1(bus.wr_ready), '0);
        host_read(csr_a(0), rd);
        check("idle_overflow_status", rd, 32'h4000_0000);

        // Arm with irq enable, readback and unused CSR
        csr_write(1, 32'h6);
        host_read(csr_a(1), rd);
        check("control_readback", rd, 32'h0000_0004);
        host_read(csr_a(2), rd);
        check("csr2_zero", rd, 32'h0);

        // Five-word block ending on wr_last
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'hA0 + i; bus.wr_last = (i == 4);
            tick();
        end
        bus.wr_en = 1'b0; bus.wr_last = 1'b0;
        check("block5_wr_ready", b1(bus.wr_ready), '0);
        check("block5_irq", b1(bus.irq), 1);
        // Host write to RAM region must be ignored
        bus.address = ram_a(0); bus.writedata = 32'hFFFF; bus.write_n = 1'b0; tick(); bus.write_n = 1'b1;
        host_read(csr_a(0), rd);
        check("block5_status", rd, 32'hC000_0005);
        for (int i = 0; i < 5; i++) begin
            host_read(ram_a(i), rd);
            check("block5_ram", rd, 32'hA0 + i);
        end

        // Clear and arm together: clear wins
        csr_write(1, 32'h3);
        tick(); tick();
        check("clr_arm_wr_ready", b1(bus.wr_ready), '0);
        host_read(csr_a(0), rd);
        check("clr_arm_status", rd, 32'h0);

        // Full buffer without wr_last, then one extra word dropped
        csr_write(1, 32'h6);
        for (int i = 0; i <= DEPTH; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'h1000 + i;
            tick();
            if (i == DEPTH - 2) check("full_ready_before", b1(bus.wr_ready), 1);
            if (i == DEPTH - 1) check("full_ready_after", b1(bus.wr_ready), '0);
        end
        bus.wr_en = 1'b0;
        check("full_irq", b1(bus.irq), 1);
        host_read(csr_a(0), rd);
        check("full_status", rd, 32'hC000_0400);
        host_read(ram_a(DEPTH - 1), rd);
        check("full_last_word", rd, 32'h13FF);

        // Clear coinciding with an accepted word
        csr_write(1, 32'h5);
        csr_write(1, 32'h6);
        bus.wr_en = 1'b1; bus.wr_data = 32'hDEAD;
        bus.address = csr_a(1); bus.writedata = 32'h5; bus.write_n = 1'b0;
        tick();
        bus.wr_en = 1'b0; bus.write_n = 1'b1;
        host_read(csr_a(0), rd);
        check("clr_word_status", rd, 32'h0);
        host_read(ram_a(0), rd);
        check("clr_word_discarded", rd, 32'h1000);
        csr_write(1, 32'h6);
        bus.wr_en = 1'b1; bus.wr_data = 32'h55; tick(); bus.wr_en = 1'b0;
        host_read(ram_a(0), rd);
        check("rearm_addr0", rd, 32'h55);
        host_read(csr_a(0), rd);
        check("rearm_status", rd, 32'h2000_0001);

        // Read-during-write on address 1, then re-read
        bus.wr_en = 1'b1; bus.wr_data = 32'h77;
        bus.address = ram_a(1); bus.read_n = 1'b0;
        tick();
        bus.wr_en = 1'b0;
        tick();
        bus.read_n = 1'b1;
        check("rdw_old", bus.readdata, 32'h1001);
        tick();
        check("rdw_new", bus.readdata, 32'h77);

        // Reset mid-capture at count 3
        csr_write(1, 32'h5);
        csr_write(1, 32'h6);
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 32'hB0 + i; tick();
        end
        bus.wr_en = 1'b0;
        host_read(csr_a(0), rd);
        check("pre_reset_status", rd, 32'h2000_0003);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_reset_wr_ready", b1(bus.wr_ready), '0);
        check("mid_reset_irq", b1(bus.irq), '0);
        check("mid_reset_readdata", bus.readdata, '0);
        host_read(csr_a(0), rd);
        check("mid_reset_status", rd, 32'h0);
        for (int i = 0; i < 3; i++) begin
            host_read(ram_a(i), rd);
            check("ram_kept", rd, 32'hB0 + i);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
